par_tx_ctrl: RTL
================

PAR_TX_CTRL -- requirements
Module: par_tx_ctrl

Interface
REQ-001 Parameter: PARITY_ODD, default 0, 0 = even parity bit, 1 = odd parity bit.
REQ-002 Parameter: BIT_CYCLES, default 4, clock cycles per serial bit, legal range 1..255.
REQ-003 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: req0_valid  input  1  requester 0 has a nibble to send.
REQ-006 Port: req0_data  input  4  requester 0 nibble.
REQ-007 Port: req0_ready  output  1  requester 0 nibble accepted this cycle when req0_valid is also high.
REQ-008 Port: req1_valid / req1_data / req1_ready  input 1 / input 4 / output 1  requester 1, same meaning as requester 0.
REQ-009 Port: tx_out  output  1  serial line, idle high.
REQ-010 Port: tx_busy  output  1  frame in progress.
REQ-011 Port: tx_src  output  1  index of the requester whose frame is on the line.
REQ-012 Port: frame_done  output  1  one-cycle pulse in the final cycle of the stop bit.

Function
REQ-013 States: IDLE, START, DATA, PARITY, STOP; frame is start(0), d[0], d[1], d[2], d[3], parity, stop(1), LSB first.
REQ-014 Each frame bit is held on tx_out for exactly BIT_CYCLES cycles, counted by a cycle counter that clears on every bit change.
REQ-015 Parity bit = XOR of d[3:0] when PARITY_ODD=0, inverted XOR when PARITY_ODD=1, computed from the latched nibble.
REQ-016 readyN is combinational: high only in IDLE, only when reqN_valid is high, and only when requester N holds the grant.
REQ-017 Grant is round-robin: with one valid requester, it is granted; with both valid, the requester not served last is granted.
REQ-018 On the accept edge: nibble and tx_src are latched, the last-served pointer is updated, and the state becomes START.
REQ-019 START is entered on the edge after accept, so the first start-bit cycle is 1 cycle after the accept cycle.
REQ-020 DATA steps a 2-bit bit index 0..3; after index 3 the state becomes PARITY, then STOP, then IDLE.
REQ-021 Frame length is 7*BIT_CYCLES cycles; the minimum accept-to-accept spacing is 7*BIT_CYCLES+1 cycles, because IDLE lasts at least one cycle.
REQ-022 tx_busy is high in START, DATA, PARITY and STOP, and low in IDLE.
REQ-023 tx_out is 1 in IDLE; tx_out, tx_busy, tx_src and frame_done are registered outputs.
REQ-024 reqN_data changing while reqN_valid is high and not accepted has no effect; only the value present at the accept edge is sent.
REQ-025 A requester dropping valid before grant loses nothing and is not treated as served.

Reset
REQ-026 rst high at a clock edge forces state IDLE, tx_out=1, tx_busy=0, tx_src=0, frame_done=0, counters=0, and a last-served pointer such that requester 0 wins the first tie.
REQ-027 rst asserted mid-frame aborts the frame immediately; no stop bit or frame_done is produced, and the aborted nibble is discarded.
REQ-028 While rst is high, req0_ready and req1_ready are 0.

Structure
REQ-029 A shared package par_pkg holds the state encoding, the frame bit count constant (7) and the data width constant (4).
REQ-030 The round-robin grant logic is one sub-module, par_rr_arb: inputs valid[1:0], enable and the update strobe; outputs grant[1:0] and the last-served pointer.

Verification
REQ-031 BIT_CYCLES=4, PARITY_ODD=0, ch0 sends 4'b1011 -> tx_out 0,1,1,0,1,1,1, each for 4 cycles; frame_done at cycle 28; tx_src=0.
REQ-032 PARITY_ODD=1, ch1 sends 4'b0000 -> parity bit 1; ch1 sends 4'b0001 -> parity bit 0.
REQ-033 Both valid continuously after reset -> grants alternate ch0, ch1, ch0, ...; accept edges are 29 cycles apart with BIT_CYCLES=4.
REQ-034 rst pulsed during the DATA bit index 2 -> next cycle tx_out=1 and tx_busy=0, no frame_done; the next tie is granted to ch0.
REQ-035 BIT_CYCLES=1 -> a 7-cycle frame; ch0 valid held high sends back-to-back frames with exactly one idle-high cycle between them.
REQ-036 reqN_data changed on every cycle while waiting for grant -> the serialized nibble equals the data value at the accept edge.

Source files
------------

// File: rtl/par_pkg.sv
// rtl/par_pkg.sv - shared types and constants for the parity serial transmitter
// Purpose: state encoding, frame/data width constants and the parity helper.
// Ports: none (package).
package par_pkg;

   localparam int FRAME_BITS = 7;   // start + 4 data + parity + stop
   localparam int DATA_W     = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } par_state_e;

   // Even parity is the plain XOR; odd parity is its inverse.
   function automatic logic parity_bit(input logic [DATA_W-1:0] d, input logic odd);
      return (^d) ^ odd;
   endfunction

endpackage

// File: rtl/par_rr_arb.sv
// rtl/par_rr_arb.sv - two-way round-robin arbiter
// Purpose: picks one of two requesters, favouring the one not served last.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   valid[1:0]   requester valids
//   enable       grant allowed this cycle
//   update       accept strobe; records the granted index as last served
//   grant[1:0]   one-hot grant (combinational)
//   last_served  index of the requester served most recently
module par_rr_arb (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] valid,
   input  logic       enable,
   input  logic       update,
   output logic [1:0] grant,
   output logic       last_served
);

   always_comb begin
      grant = 2'b00;
      if (enable) begin
         case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_served ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

   // Reset value 1 makes requester 0 win the first tie.
   always_ff @(posedge clk) begin
      if (rst)
         last_served <= 1'b1;
      else if (update)
         last_served <= grant[1];
   end

endmodule

// File: rtl/par_tx_ctrl.sv
// rtl/par_tx_ctrl.sv - two-requester nibble serializer with parity
// Purpose: arbitrates two nibble sources and sends start/4 data/parity/stop frames.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   req0_valid/req0_data/req0_ready   requester 0 handshake
//   req1_valid/req1_data/req1_ready   requester 1 handshake
//   tx_out                            serial line, idle high
//   tx_busy                           frame in progress
//   tx_src                            requester owning the current frame
//   frame_done                        pulse in the last cycle of the stop bit
module par_tx_ctrl
   import par_pkg::*;
#(
   parameter int PARITY_ODD = 0,
   parameter int BIT_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic              tx_out,
   output logic              tx_busy,
   output logic              tx_src,
   output logic              frame_done
);

   localparam logic [7:0] LAST_CNT = 8'(BIT_CYCLES - 1);

   par_state_e        state;
   logic [7:0]        cnt;
   logic [1:0]        bit_idx;
   logic [1:0]        next_idx;
   logic [DATA_W-1:0] nibble;
   logic [1:0]        grant;
   logic              last_served;
   logic              arb_en;
   logic              accept;
   logic              bit_done;

   assign arb_en     = (state == ST_IDLE) && !rst;
   assign accept     = |grant;
   assign req0_ready = grant[0];
   assign req1_ready = grant[1];
   assign bit_done   = (cnt == LAST_CNT);
   assign next_idx   = bit_idx + 2'd1;

   par_rr_arb u_arb (
      .clk         (clk),
      .rst         (rst),
      .valid       ({req1_valid, req0_valid}),
      .enable      (arb_en),
      .update      (accept),
      .grant       (grant),
      .last_served (last_served)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         tx_out     <= 1'b1;
         tx_busy    <= 1'b0;
         tx_src     <= 1'b0;
         frame_done <= 1'b0;
         cnt        <= 8'd0;
         bit_idx    <= 2'd0;
         nibble     <= '0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  nibble  <= grant[1] ? req1_data : req0_data;
                  tx_src  <= grant[1];
                  state   <= ST_START;
                  tx_out  <= 1'b0;
                  tx_busy <= 1'b1;
                  cnt     <= 8'd0;
               end
            end
            ST_START: begin
               if (bit_done) begin
                  cnt     <= 8'd0;
                  bit_idx <= 2'd0;
                  state   <= ST_DATA;
                  tx_out  <= nibble[0];
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            ST_DATA: begin
               if (bit_done) begin
                  cnt <= 8'd0;
                  if (bit_idx == 2'd3) begin
                     state  <= ST_PARITY;
                     tx_out <= parity_bit(nibble, PARITY_ODD != 0);
                  end else begin
                     bit_idx <= next_idx;
                     tx_out  <= nibble[next_idx];
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            ST_PARITY: begin
               if (bit_done) begin
                  cnt        <= 8'd0;
                  state      <= ST_STOP;
                  tx_out     <= 1'b1;
                  // A one-cycle stop bit is its own final cycle.
                  frame_done <= (BIT_CYCLES == 1);
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            ST_STOP: begin
               if (bit_done) begin
                  cnt     <= 8'd0;
                  state   <= ST_IDLE;
                  tx_busy <= 1'b0;
               end else begin
                  cnt        <= cnt + 8'd1;
                  frame_done <= ((cnt + 8'd1) == LAST_CNT);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // While a frame is on the line, the arbiter's pointer names its owner.
   always @(posedge clk) begin
      if (!rst && state != ST_IDLE)
         assert (last_served == tx_src);
   end

endmodule
